// File: rtl/ring_router_vc.sv
`default_nettype none
// ============================================================================
//  Module      : ring_router_vc
//  Description : Bidirectional ring router with NUM_VC packet slots on each of
//                the left, right and host inputs. Left input goes right and
//                right input goes left. Host injections take the shorter ring
//                direction. Packets addressed to this router are ejected to the
//                host. Each output has a 1-bit round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_router_vc #(
  parameter int ROUTER_ID   = 0,
  parameter int PACKET_SIZE = 8,
  parameter int ROUTER_BITS = 2,
  parameter int NUM_VC      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PACKET_SIZE-1:0] left_data_in,
  input  logic                   left_enable_in,
  input  logic                   left_in_buffer_full,
  output logic                   left_out_buffer_full,
  output logic [PACKET_SIZE-1:0] left_data_out,
  output logic                   left_enable_out,
  input  logic [PACKET_SIZE-1:0] right_data_in,
  input  logic                   right_enable_in,
  input  logic                   right_in_buffer_full,
  output logic                   right_out_buffer_full,
  output logic [PACKET_SIZE-1:0] right_data_out,
  output logic                   right_enable_out,
  input  logic [PACKET_SIZE-1:0] host_data_in,
  input  logic                   host_enable_in,
  output logic                   host_out_buffer_full,
  output logic [PACKET_SIZE-1:0] host_data_out,
  output logic                   host_enable_out
);

  localparam int                     NUM_ROUTERS = 2 ** ROUTER_BITS;
  localparam logic [ROUTER_BITS-1:0] MY_ID       = ROUTER_BITS'(ROUTER_ID);
  localparam logic [ROUTER_BITS:0]   HALF_DIST   = (ROUTER_BITS+1)'(NUM_ROUTERS / 2);

  typedef logic [NUM_VC-1:0]                  mask_t;
  typedef logic [PACKET_SIZE-1:0]             pkt_t;
  typedef logic [NUM_VC-1:0][PACKET_SIZE-1:0] slots_t;

  // One-hot of the lowest set bit (all zero when nothing is set)
  function automatic mask_t lowest1(input mask_t m);
    mask_t r;
    logic  found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (m[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // AND-OR mux of the slot selected by a one-hot mask
  function automatic pkt_t pick(input mask_t oh, input slots_t s);
    pkt_t r;
    r = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      r = r | (s[i] & {PACKET_SIZE{oh[i]}});
    end
    return r;
  endfunction

  // Clockwise distance from this router to the packet destination
  function automatic logic [ROUTER_BITS-1:0] host_dist(input pkt_t p);
    return p[ROUTER_BITS-1:0] - MY_ID;
  endfunction

  // Slot state
  mask_t  left_vld_q, right_vld_q, host_vld_q;
  mask_t  left_vld_d, right_vld_d, host_vld_d;
  slots_t left_pkt_q, right_pkt_q, host_pkt_q;
  mask_t  left_wr, right_wr, host_wr;
  mask_t  left_clr, right_clr, host_clr;

  // Routing masks: <source>_to_<output>
  mask_t left_to_host, left_to_right;
  mask_t right_to_host, right_to_left;
  mask_t host_to_host, host_to_right, host_to_left;

  // Per-output arbitration results
  logic  rout_grant, rout_sel_b, rr_right_q, rr_right_d;
  mask_t rout_oh_a, rout_oh_b, rout_clr_a, rout_clr_b;
  pkt_t  rout_pkt;
  logic  lout_grant, lout_sel_b, rr_left_q, rr_left_d;
  mask_t lout_oh_a, lout_oh_b, lout_clr_a, lout_clr_b;
  pkt_t  lout_pkt;
  logic  hout_grant, hout_sel_b, rr_host_q, rr_host_d;
  mask_t hout_oh_a, hout_oh_b, hout_oh_c, hout_clr_a, hout_clr_b, hout_clr_c;
  pkt_t  hout_pkt;

  // Registered outputs
  pkt_t left_data_q, right_data_q, host_data_q;
  logic left_en_q, right_en_q, host_en_q;

  assign left_out_buffer_full  = &left_vld_q;
  assign right_out_buffer_full = &right_vld_q;
  assign host_out_buffer_full  = &host_vld_q;

  // Classify every valid slot by the one output it targets
  always_comb begin
    left_to_host  = '0;
    left_to_right = '0;
    right_to_host = '0;
    right_to_left = '0;
    host_to_host  = '0;
    host_to_right = '0;
    host_to_left  = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (left_vld_q[i]) begin
        if (left_pkt_q[i][ROUTER_BITS-1:0] == MY_ID) left_to_host[i]  = 1'b1;
        else                                         left_to_right[i] = 1'b1;
      end
      if (right_vld_q[i]) begin
        if (right_pkt_q[i][ROUTER_BITS-1:0] == MY_ID) right_to_host[i] = 1'b1;
        else                                          right_to_left[i] = 1'b1;
      end
      if (host_vld_q[i]) begin
        if (host_dist(host_pkt_q[i]) == '0)
          host_to_host[i] = 1'b1;
        else if ({1'b0, host_dist(host_pkt_q[i])} <= HALF_DIST)
          host_to_right[i] = 1'b1;
        else
          host_to_left[i] = 1'b1;
      end
    end
  end

  // Right output: sources {left, host}, pointer 0 favours left
  always_comb begin
    rout_oh_a  = lowest1(left_to_right);
    rout_oh_b  = lowest1(host_to_right);
    rout_grant = !right_in_buffer_full && ((|left_to_right) || (|host_to_right));
    rout_sel_b = ((|left_to_right) && (|host_to_right)) ? rr_right_q : (|host_to_right);
    rout_pkt   = rout_sel_b ? pick(rout_oh_b, host_pkt_q) : pick(rout_oh_a, left_pkt_q);
    rout_clr_a = (rout_grant && !rout_sel_b) ? rout_oh_a : '0;
    rout_clr_b = (rout_grant &&  rout_sel_b) ? rout_oh_b : '0;
    rr_right_d = rout_grant ? !rout_sel_b : rr_right_q;
  end

  // Left output: sources {right, host}, pointer 0 favours right
  always_comb begin
    lout_oh_a  = lowest1(right_to_left);
    lout_oh_b  = lowest1(host_to_left);
    lout_grant = !left_in_buffer_full && ((|right_to_left) || (|host_to_left));
    lout_sel_b = ((|right_to_left) && (|host_to_left)) ? rr_left_q : (|host_to_left);
    lout_pkt   = lout_sel_b ? pick(lout_oh_b, host_pkt_q) : pick(lout_oh_a, right_pkt_q);
    lout_clr_a = (lout_grant && !lout_sel_b) ? lout_oh_a : '0;
    lout_clr_b = (lout_grant &&  lout_sel_b) ? lout_oh_b : '0;
    rr_left_d  = lout_grant ? !lout_sel_b : rr_left_q;
  end

  // Host output: ring sources {left, right} round-robin; host loopback is
  // served only in cycles where no ring packet is ejecting, and it does not
  // disturb the pointer, so ring traffic keeps its fairness guarantee.
  always_comb begin
    hout_oh_a  = lowest1(left_to_host);
    hout_oh_b  = lowest1(right_to_host);
    hout_oh_c  = lowest1(host_to_host);
    hout_sel_b = ((|left_to_host) && (|right_to_host)) ? rr_host_q : (|right_to_host);
    hout_clr_a = '0;
    hout_clr_b = '0;
    hout_clr_c = '0;
    hout_pkt   = '0;
    rr_host_d  = rr_host_q;
    hout_grant = 1'b0;
    if ((|left_to_host) || (|right_to_host)) begin
      hout_grant = 1'b1;
      rr_host_d  = !hout_sel_b;
      if (hout_sel_b) begin
        hout_pkt   = pick(hout_oh_b, right_pkt_q);
        hout_clr_b = hout_oh_b;
      end else begin
        hout_pkt   = pick(hout_oh_a, left_pkt_q);
        hout_clr_a = hout_oh_a;
      end
    end else if (|host_to_host) begin
      hout_grant = 1'b1;
      hout_pkt   = pick(hout_oh_c, host_pkt_q);
      hout_clr_c = hout_oh_c;
    end
  end

  // Capture into the lowest free slot; granted slots are released this edge
  always_comb begin
    left_wr    = (left_enable_in  && !left_out_buffer_full)  ? lowest1(~left_vld_q)  : '0;
    right_wr   = (right_enable_in && !right_out_buffer_full) ? lowest1(~right_vld_q) : '0;
    host_wr    = (host_enable_in  && !host_out_buffer_full)  ? lowest1(~host_vld_q)  : '0;
    left_clr   = rout_clr_a | hout_clr_a;
    right_clr  = lout_clr_a | hout_clr_b;
    host_clr   = rout_clr_b | lout_clr_b | hout_clr_c;
    left_vld_d  = (left_vld_q  & ~left_clr)  | left_wr;
    right_vld_d = (right_vld_q & ~right_clr) | right_wr;
    host_vld_d  = (host_vld_q  & ~host_clr)  | host_wr;
  end

  // Slot valid bits and packet storage for all three inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_vld_q  <= '0;
      right_vld_q <= '0;
      host_vld_q  <= '0;
      left_pkt_q  <= '0;
      right_pkt_q <= '0;
      host_pkt_q  <= '0;
    end else begin
      left_vld_q  <= left_vld_d;
      right_vld_q <= right_vld_d;
      host_vld_q  <= host_vld_d;
      for (int i = 0; i < NUM_VC; i++) begin
        if (left_wr[i])  left_pkt_q[i]  <= left_data_in;
        if (right_wr[i]) right_pkt_q[i] <= right_data_in;
        if (host_wr[i])  host_pkt_q[i]  <= host_data_in;
      end
    end
  end

  // Round-robin pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_right_q <= 1'b0;
      rr_left_q  <= 1'b0;
      rr_host_q  <= 1'b0;
    end else begin
      rr_right_q <= rr_right_d;
      rr_left_q  <= rr_left_d;
      rr_host_q  <= rr_host_d;
    end
  end

  // Output registers: enable pulses on grant, data holds when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_data_q  <= '0;
      right_data_q <= '0;
      host_data_q  <= '0;
      left_en_q    <= 1'b0;
      right_en_q   <= 1'b0;
      host_en_q    <= 1'b0;
    end else begin
      left_en_q  <= lout_grant;
      right_en_q <= rout_grant;
      host_en_q  <= hout_grant;
      if (lout_grant) left_data_q  <= lout_pkt;
      if (rout_grant) right_data_q <= rout_pkt;
      if (hout_grant) host_data_q  <= hout_pkt;
    end
  end

  assign left_data_out    = left_data_q;
  assign right_data_out   = right_data_q;
  assign host_data_out    = host_data_q;
  assign left_enable_out  = left_en_q;
  assign right_enable_out = right_en_q;
  assign host_enable_out  = host_en_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_router_vc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_router_vc
//  Description : Self-checking bench for ring_router_vc (ROUTER_ID=1, 4-node
//                ring, 2 slots per input). Expected packets are queued per
//                output when stimulus is driven and matched as they emerge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_router_vc;

  localparam int PS = 8;

  typedef struct { logic [PS-1:0] pkt; int due; } exp_t;
  typedef struct { int src; logic [PS-1:0] pkt; int dst; } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PS-1:0] left_data_in = '0, right_data_in = '0, host_data_in = '0;
  logic          left_enable_in = 1'b0, right_enable_in = 1'b0, host_enable_in = 1'b0;
  logic          left_in_buffer_full = 1'b0, right_in_buffer_full = 1'b0;
  logic          left_out_buffer_full, right_out_buffer_full, host_out_buffer_full;
  logic [PS-1:0] left_data_out, right_data_out, host_data_out;
  logic          left_enable_out, right_enable_out, host_enable_out;

  exp_t  q_left[$];
  exp_t  q_right[$];
  exp_t  q_host[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  string nm[3] = '{"left", "right", "host"};
  vec_t  vecs[9];
  int    rel;

  ring_router_vc #(
    .ROUTER_ID(1), .PACKET_SIZE(PS), .ROUTER_BITS(2), .NUM_VC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .left_data_in(left_data_in), .left_enable_in(left_enable_in),
    .left_in_buffer_full(left_in_buffer_full), .left_out_buffer_full(left_out_buffer_full),
    .left_data_out(left_data_out), .left_enable_out(left_enable_out),
    .right_data_in(right_data_in), .right_enable_in(right_enable_in),
    .right_in_buffer_full(right_in_buffer_full), .right_out_buffer_full(right_out_buffer_full),
    .right_data_out(right_data_out), .right_enable_out(right_enable_out),
    .host_data_in(host_data_in), .host_enable_in(host_enable_in),
    .host_out_buffer_full(host_out_buffer_full),
    .host_data_out(host_data_out), .host_enable_out(host_enable_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push(input int o, input logic [PS-1:0] p, input int due);
    exp_t e;
    e.pkt = p;
    e.due = due;
    case (o)
      0:       q_left.push_back(e);
      1:       q_right.push_back(e);
      default: q_host.push_back(e);
    endcase
  endtask

  // Match one output against the head of its expected queue
  task automatic mon(input int o, input logic en, input logic [PS-1:0] d);
    exp_t e;
    bit   have;
    if (en !== 1'b0) begin
      total++;
      have = 1'b0;
      case (o)
        0:       if (q_left.size()  > 0) begin e = q_left.pop_front();  have = 1'b1; end
        1:       if (q_right.size() > 0) begin e = q_right.pop_front(); have = 1'b1; end
        default: if (q_host.size()  > 0) begin e = q_host.pop_front();  have = 1'b1; end
      endcase
      if (!have) begin
        bad++;
        $display("FAIL %s_unexpected: got data=%h en=%b at cycle %0d, required no packet",
                 nm[o], d, en, cyc);
      end else if (en !== 1'b1 || d !== e.pkt || (e.due >= 0 && cyc != e.due)) begin
        bad++;
        $display("FAIL %s_packet: got data=%h at cycle %0d, required data=%h at cycle %0d",
                 nm[o], d, cyc, e.pkt, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon(0, left_enable_out,  left_data_out);
      mon(1, right_enable_out, right_data_out);
      mon(2, host_enable_out,  host_data_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int src, input logic [PS-1:0] p);
    case (src)
      0:       begin left_data_in  = p; left_enable_in  = 1'b1; end
      1:       begin right_data_in = p; right_enable_in = 1'b1; end
      default: begin host_data_in  = p; host_enable_in  = 1'b1; end
    endcase
  endtask

  task automatic idle();
    left_enable_in  = 1'b0;
    right_enable_in = 1'b0;
    host_enable_in  = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_left_data"},  32'(left_data_out),    32'h0);
    chk({tag, "_right_data"}, 32'(right_data_out),   32'h0);
    chk({tag, "_host_data"},  32'(host_data_out),    32'h0);
    chk({tag, "_enables"},    32'({left_enable_out, right_enable_out, host_enable_out}), 32'h0);
    chk({tag, "_full_flags"}, 32'({left_out_buffer_full, right_out_buffer_full, host_out_buffer_full}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // src/dst: 0=left 1=right 2=host; this router is node 1 of 4
    vecs[0] = '{0, 8'hA3, 1};   // dest 3 passes through to the right
    vecs[1] = '{0, 8'h51, 2};   // dest 1 is ejected
    vecs[2] = '{2, 8'h40, 0};   // dist 3 goes left
    vecs[3] = '{2, 8'h43, 1};   // dist 2 goes right
    vecs[4] = '{2, 8'h41, 2};   // dist 0 loops back
    vecs[5] = '{1, 8'h50, 0};   // from right, dest 0 keeps going left
    vecs[6] = '{1, 8'h7D, 2};   // from right, dest 1 is ejected
    vecs[7] = '{2, 8'h42, 1};   // dist 1 goes right
    vecs[8] = '{0, 8'h0C, 1};   // from left, dest 0 keeps going right

    // Reset is asserted before the first clock edge
    #1 rst = 1'b1;
    #2;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Single uncontended packets: one-edge latency, one-cycle pulse
    for (int i = 0; i < 9; i++) begin
      push(vecs[i].dst, vecs[i].pkt, cyc + 2);
      drive(vecs[i].src, vecs[i].pkt);
      step();
      idle();
      repeat (3) step();
      chk($sformatf("vec%0d_drain", i), 32'(q_left.size() + q_right.size() + q_host.size()), 32'h0);
    end

    // Backpressure on the right output fills the left input slots
    right_in_buffer_full = 1'b1;
    drive(0, 8'h12);
    step();
    drive(0, 8'h22);
    step();
    idle();
    chk("bp_full_set", 32'(left_out_buffer_full), 32'h1);
    drive(0, 8'h32);
    step();
    idle();
    chk("bp_full_hold", 32'(left_out_buffer_full), 32'h1);
    push(1, 8'h12, cyc + 1);
    push(1, 8'h22, cyc + 2);
    right_in_buffer_full = 1'b0;
    step();
    chk("bp_full_fall", 32'(left_out_buffer_full), 32'h0);
    repeat (4) step();
    chk("bp_drain", 32'(q_right.size()), 32'h0);

    // Asynchronous reset between edges while packets are buffered
    right_in_buffer_full = 1'b1;
    drive(0, 8'h13);
    step();
    drive(0, 8'h23);
    step();
    idle();
    chk("rst_pre_full", 32'(left_out_buffer_full), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk_outputs_zero("async_rst");
    #1 rst = 1'b0;
    right_in_buffer_full = 1'b0;
    repeat (6) step();
    chk("rst_no_leftover", 32'(left_out_buffer_full), 32'h0);

    // Round-robin on the right output: left and host kept saturated
    right_in_buffer_full = 1'b1;
    for (int k = 0; k < 8 && !(left_out_buffer_full && host_out_buffer_full); k++) begin
      left_data_in   = 8'hA2;
      left_enable_in = !left_out_buffer_full;
      host_data_in   = 8'hB3;
      host_enable_in = !host_out_buffer_full;
      step();
    end
    idle();
    chk("rr_filled", 32'({left_out_buffer_full, host_out_buffer_full}), 32'h3);
    rel = cyc;
    for (int k = 1; k <= 8; k++) push(1, (k % 2 == 1) ? 8'hA2 : 8'hB3, rel + k);
    right_in_buffer_full = 1'b0;
    for (int k = 0; k < 8; k++) begin
      left_data_in   = 8'hA2;
      left_enable_in = !left_out_buffer_full;
      host_data_in   = 8'hB3;
      host_enable_in = !host_out_buffer_full;
      step();
    end
    right_in_buffer_full = 1'b1;
    idle();
    repeat (2) step();
    chk("rr_drain", 32'(q_right.size()), 32'h0);
    chk("rr_other_outputs", 32'(q_left.size() + q_host.size()), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    right_in_buffer_full = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ring_router_vc.md
# ring_router_vc

Parametrised bidirectional ring router with per-port virtual-channel slots, a local host port, and round-robin output arbitration. Successor to the two-VC left-to-right ring router.
- Packets entering from the left travel right; packets entering from the right travel left.
- Host-injected packets take the shorter ring direction.
- Packets addressed to this router are ejected to the host port.
- Each router instance sits between two ring neighbours and one local host.

## Interface
Parameters:
- ROUTER_ID, 0, this router's address (0 .. 2**ROUTER_BITS-1)
- PACKET_SIZE, 8, packet width; bits [ROUTER_BITS-1:0] hold the destination, the rest is payload
- ROUTER_BITS, 2, address width; ring size NUM_ROUTERS = 2**ROUTER_BITS
- NUM_VC, 2, VC slots per input port (left, right, host); must be ≥1

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- left_data_in  in  PACKET_SIZE  packet from left neighbour
- left_enable_in  in  1  left_data_in valid
- left_in_buffer_full  in  1  left neighbour cannot accept
- left_out_buffer_full  out  1  all left-input slots occupied
- left_data_out  out  PACKET_SIZE  packet to left neighbour
- left_enable_out  out  1  left_data_out valid (one-cycle pulse per packet)
- right_data_in, right_enable_in, right_in_buffer_full, right_out_buffer_full, right_data_out, right_enable_out: mirror of the left-side ports
- host_data_in  in  PACKET_SIZE  packet injected by host
- host_enable_in  in  1  host_data_in valid
- host_out_buffer_full  out  1  all host-input slots occupied
- host_data_out  out  PACKET_SIZE  ejected packet
- host_enable_out  out  1  host_data_out valid (host always accepts)

## Operation
- **Slots.** Each input port has NUM_VC slots, each holding a valid bit and a packet.
- **Capture.** On a clock edge with enable_in=1 and at least one slot free (judged at start of cycle), the packet is written into the lowest-index free slot.
- **Full input.** An enable_in while that port is full is ignored and the packet is dropped. Upstream must not do this.
- **Full flags.** *_out_buffer_full = AND of that port's slot valid bits. It is combinational from registered state, so there is no extra delay.
- **Routing per valid slot**, with dest = slot[ROUTER_BITS-1:0]:
  - Left- or right-input slot with dest==ROUTER_ID goes to the host output.
  - Left-input slot otherwise goes to the right output.
  - Right-input slot otherwise goes to the left output.
  - Host slot computes dist = (dest - ROUTER_ID) mod NUM_ROUTERS, in ROUTER_BITS-wide wraparound subtraction:
    - dist==0 goes to the host output (loopback).
    - 1 ≤ dist ≤ NUM_ROUTERS/2 goes to the right output.
    - dist > NUM_ROUTERS/2 goes to the left output.
- **Source candidates per output:**
  - Right output: {left, host}.
  - Left output: {right, host}.
  - Host output: {left, right}.
- **Slot selection within a source:** the lowest-index slot routed to that output.
- **Arbitration.** Each output has a 1-bit round-robin pointer.
  - If both sources have candidates, the source named by the pointer wins, and the pointer flips to the other source after the grant.
  - If only one source has a candidate, it wins and the pointer is set to the other source.
- **Backpressure.** The left and right outputs grant only when their in_buffer_full=0 in that cycle. The host output always grants.
- **On a grant:** data_out and enable_out are registered at the edge and the granted slot's valid bit is cleared at the same edge.
- **No grant:** enable_out=0 and data_out holds its last value.
- **Concurrency.** The three outputs grant independently in the same cycle. A slot targets exactly one output, so a slot is never double-granted.
- **Slot reuse.** A slot freed at edge k is writable from edge k+1.

## Timing
- **Reset.** While rst=1, asynchronously and immediately:
  - All slots are invalid.
  - All *_data_out = 0 and all *_enable_out = 0.
  - All *_out_buffer_full = 0.
  - Round-robin pointers = 0, meaning the first-listed source has priority.
- **Reset mid-operation** discards all buffered packets; there is no partial output.
- **Latency.** A packet captured at edge k appears on its data_out with enable_out=1 after edge k+1, if uncontended and not backpressured.
- **Throughput.** Each output sends at most one packet per cycle. Each input accepts at most one packet per cycle.
- **Full flag rises** in the cycle after the edge that fills the last slot.
- **Full flag falls** in the cycle after the edge that frees a slot.

## Test plan
Configuration for all scenarios: ROUTER_ID=1, ROUTER_BITS=2, PACKET_SIZE=8, NUM_VC=2.
- **Async reset:** pulse rst between edges while traffic is buffered -> all outputs 0 immediately, before any edge; buffered packets are not emitted afterwards.
- **Pass-through:** left_data_in=8'hA3 (dest 3) for one cycle, right_in_buffer_full=0 -> right_data_out=8'hA3 with right_enable_out=1 for exactly one cycle, one edge after capture.
- **Ejection:** left_data_in=8'h51 (dest 1) -> host_data_out=8'h51 with a host_enable_out pulse; right_enable_out stays 0.
- **Backpressure:**
  - Stimulus: hold right_in_buffer_full=1; inject 8'h12 then 8'h22 on the left.
  - Required: left_out_buffer_full=1 after the second capture; a third packet, 8'h32, is ignored.
  - On release: 8'h12 then 8'h22 appear on consecutive cycles, and 8'h32 never appears.
- **Host shortest path:**
  - Host injects 8'h40 (dist 3) -> appears on left_data_out.
  - Host injects 8'h43 (dist 2) -> appears on right_data_out.
  - Host injects 8'h41 -> appears on host_data_out.
- **Round-robin contention:** keep both left-input slots full of dest 2 and both host slots full of dest 3 -> right output alternates left, host, left, host starting with left after reset; there are no idle cycles.
